// File: rtl/pattern_fsm_param.sv
// rtl/pattern_fsm_param.sv - parameterised serial pattern detector with saturating match counter
// State k means the last k consumed bits equal the first k pattern bits.
module pattern_fsm_param #(
    parameter int                 PAT_LEN = 3,
    parameter logic [PAT_LEN-1:0] PATTERN = 3'b010,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       data_in,
    input  logic                       clr_cnt,
    output logic                       match,
    output logic [CNT_W-1:0]           match_cnt,
    output logic [$clog2(PAT_LEN)-1:0] prog
);

    localparam int PW = $clog2(PAT_LEN);
    localparam int NS = 2 ** PW;

    typedef logic [PW-1:0] state_t;

    if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_pat_len
        $error("pattern_fsm_param: PAT_LEN must be in 2..16");
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
        $error("pattern_fsm_param: CNT_W must be in 1..32");
    end

    // Pattern bit i in arrival order (bit 0 is received first).
    function automatic bit pat_bit(input int i);
        return PATTERN[PAT_LEN-1-i];
    endfunction

    // Longest proper pattern prefix that is a suffix of (first k pattern bits, then b).
    function automatic int fallback(input int k, input bit b);
        int  best;
        bit  ok;
        int  idx;
        best = 0;
        if (k < PAT_LEN) begin
            for (int len = 1; len <= k; len++) begin
                ok = 1'b1;
                for (int m = 0; m < len; m++) begin
                    idx = k + 1 - len + m;
                    if (((idx == k) ? b : pat_bit(idx)) != pat_bit(m)) ok = 1'b0;
                end
                if (ok) best = len;
            end
        end
        return best;
    endfunction

    function automatic logic [NS-1:0] build_fwd();
        logic [NS-1:0] v;
        v = '0;
        for (int i = 0; i < PAT_LEN; i++) v[i] = pat_bit(i);
        return v;
    endfunction

    function automatic logic [NS-1:0] build_legal();
        logic [NS-1:0] v;
        v = '0;
        for (int i = 0; i < PAT_LEN; i++) v[i] = 1'b1;
        return v;
    endfunction

    localparam logic [NS-1:0] PAT_FWD    = build_fwd();
    localparam logic [NS-1:0] LEGAL      = build_legal();
    localparam state_t        S0         = '0;
    localparam state_t        LAST       = state_t'(PAT_LEN - 1);
    localparam state_t        MATCH_NEXT = OVERLAP ? state_t'(fallback(PAT_LEN - 1, pat_bit(PAT_LEN - 1))) : S0;

    // Mismatch targets, indexed by {state, incoming bit}; constant after elaboration.
    state_t fb_tab [2*NS];
    for (genvar i = 0; i < 2 * NS; i++) begin : g_fb
        assign fb_tab[i] = state_t'(fallback(i / 2, (i % 2) == 1));
    end

    state_t           state_q, state_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        match_d = 1'b0;
        if (!LEGAL[state_q]) begin
            state_d = S0;
        end else if (en) begin
            if (data_in == PAT_FWD[state_q]) begin
                if (state_q == LAST) begin
                    match_d = 1'b1;
                    state_d = MATCH_NEXT;
                end else begin
                    state_d = state_q + 1'b1;
                end
            end else begin
                state_d = fb_tab[{state_q, data_in}];
            end
        end
    end

    // A clear that lands on a match leaves exactly that one match counted.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d    = '0;
            cnt_d[0] = match_d;
        end else if (match_d && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S0;
            match_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
        end
    end

    assign match     = match_q;
    assign match_cnt = cnt_q;
    assign prog      = state_q;

endmodule

// File: tb/tb_pattern_fsm_param.sv
// tb/tb_pattern_fsm_param.sv - four parameterisations driven in lockstep against a history-based model
module tb_pattern_fsm_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, en = 1'b0, data_in = 1'b0, clr_cnt = 1'b0;

    logic       m_def, m_nov, m_p4, m_c2;
    logic [1:0] p_def, p_nov, p_p4, p_c2;
    logic [7:0] c_def, c_nov, c_p4;
    logic [1:0] c_c2;

    pattern_fsm_param u_def (
        .clk(clk), .rst(rst), .en(en), .data_in(data_in), .clr_cnt(clr_cnt),
        .match(m_def), .match_cnt(c_def), .prog(p_def));

    pattern_fsm_param #(.OVERLAP(1'b0)) u_nov (
        .clk(clk), .rst(rst), .en(en), .data_in(data_in), .clr_cnt(clr_cnt),
        .match(m_nov), .match_cnt(c_nov), .prog(p_nov));

    pattern_fsm_param #(.PAT_LEN(4), .PATTERN(4'b1011)) u_p4 (
        .clk(clk), .rst(rst), .en(en), .data_in(data_in), .clr_cnt(clr_cnt),
        .match(m_p4), .match_cnt(c_p4), .prog(p_p4));

    pattern_fsm_param #(.CNT_W(2)) u_c2 (
        .clk(clk), .rst(rst), .en(en), .data_in(data_in), .clr_cnt(clr_cnt),
        .match(m_c2), .match_cnt(c_c2), .prog(p_c2));

    logic [3:0]      act_m;
    logic [3:0][3:0] act_p;
    logic [3:0][7:0] act_c;
    assign act_m = {m_c2, m_p4, m_nov, m_def};
    assign act_p = {{2'b0, p_c2}, {2'b0, p_p4}, {2'b0, p_nov}, {2'b0, p_def}};
    assign act_c = {{6'b0, c_c2}, c_p4, c_nov, c_def};

    int    checks   = 0;
    int    failures = 0;

    int          L   [4] = '{3, 3, 4, 3};
    logic [15:0] PAT [4] = '{16'b010, 16'b010, 16'b1011, 16'b010};
    bit          OV  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int          CW  [4] = '{8, 8, 8, 2};
    string       DN  [4] = '{"def", "nov", "p4", "c2"};

    logic [31:0] hist [4];
    int          nv   [4];
    int          mcnt [4];

    typedef struct packed {
        logic [3:0]      m;
        logic [3:0][3:0] p;
        logic [3:0][7:0] c;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit r, e, d, c;
        int m, p, cnt;
    } vec_t;
    vec_t tv[21];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Brute-force reference: match and progress derived from the consumed-bit history.
    task automatic model_step(input int d, input bit r, input bit e, input bit di, input bit cl,
                              output bit em, output int ep, output int ec);
        logic [31:0] lm;
        em = 1'b0;
        if (r) begin
            hist[d] = '0;
            nv[d]   = 0;
            mcnt[d] = 0;
        end else begin
            if (e) begin
                hist[d] = {hist[d][30:0], di};
                nv[d]++;
                lm = (32'd1 << L[d]) - 1;
                if (nv[d] >= L[d] && (hist[d] & lm) == ({16'b0, PAT[d]} & lm)) em = 1'b1;
            end
            if (cl) mcnt[d] = em ? 1 : 0;
            else if (em && mcnt[d] < (1 << CW[d]) - 1) mcnt[d]++;
            if (em && !OV[d]) nv[d] = 0;
        end
        ep = 0;
        for (int k = 1; k < L[d]; k++) begin
            lm = (32'd1 << k) - 1;
            if (k <= nv[d] && (hist[d] & lm) == (({16'b0, PAT[d]} >> (L[d] - k)) & lm)) ep = k;
        end
        ec = mcnt[d];
    endtask

    task automatic drive(input bit r, input bit e, input bit di, input bit cl);
        exp_t x, y;
        bit   em;
        int   ep, ec;
        @(negedge clk);
        rst = r; en = e; data_in = di; clr_cnt = cl;
        x = '0;
        for (int d = 0; d < 4; d++) begin
            model_step(d, r, e, di, cl, em, ep, ec);
            x.m[d] = em;
            x.p[d] = 4'(ep);
            x.c[d] = 8'(ec);
        end
        sb.push_back(x);
        @(posedge clk);
        #1;
        y = sb.pop_front();
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("sb_%s_match", DN[d]), {31'b0, act_m[d]}, {31'b0, y.m[d]});
            chk($sformatf("sb_%s_prog", DN[d]), {28'b0, act_p[d]}, {28'b0, y.p[d]});
            chk($sformatf("sb_%s_cnt", DN[d]), {24'b0, act_c[d]}, {24'b0, y.c[d]});
        end
    endtask

    initial begin
        bit s1[5]  = '{0, 1, 0, 1, 0};
        bit e1[5]  = '{0, 0, 1, 0, 0};
        bit s2[6]  = '{0, 1, 0, 0, 1, 0};
        bit e2[6]  = '{0, 0, 1, 0, 0, 1};
        bit s3[6]  = '{1, 0, 1, 0, 1, 1};
        int p3[6]  = '{1, 2, 3, 2, 3, 1};
        bit e3[6]  = '{0, 0, 0, 0, 0, 1};
        int c4[11] = '{0, 0, 1, 1, 2, 2, 3, 3, 3, 3, 3};

        // {rst, en, data_in, clr_cnt, match, prog, match_cnt} for the default instance
        tv[0]  = '{1, 0, 0, 0, 0, 0, 0};
        tv[1]  = '{0, 1, 0, 0, 0, 1, 0};
        tv[2]  = '{0, 1, 1, 0, 0, 2, 0};
        tv[3]  = '{0, 1, 0, 0, 1, 1, 1};
        tv[4]  = '{0, 1, 1, 0, 0, 2, 1};
        tv[5]  = '{0, 1, 0, 0, 1, 1, 2};
        tv[6]  = '{1, 1, 1, 1, 0, 0, 0};
        tv[7]  = '{0, 1, 0, 0, 0, 1, 0};
        tv[8]  = '{0, 1, 1, 0, 0, 2, 0};
        tv[9]  = '{0, 0, 0, 0, 0, 2, 0};
        tv[10] = '{0, 0, 1, 0, 0, 2, 0};
        tv[11] = '{0, 0, 0, 0, 0, 2, 0};
        tv[12] = '{0, 1, 0, 0, 1, 1, 1};
        tv[13] = '{0, 1, 1, 0, 0, 2, 1};
        tv[14] = '{1, 0, 0, 0, 0, 0, 0};
        tv[15] = '{0, 1, 0, 0, 0, 1, 0};
        tv[16] = '{0, 1, 1, 0, 0, 2, 0};
        tv[17] = '{0, 1, 0, 1, 1, 1, 1};
        tv[18] = '{0, 1, 1, 1, 0, 2, 0};
        tv[19] = '{0, 1, 1, 0, 0, 0, 0};
        tv[20] = '{0, 1, 1, 0, 0, 0, 0};

        for (int i = 0; i < 21; i++) begin
            drive(tv[i].r, tv[i].e, tv[i].d, tv[i].c);
            chk($sformatf("vec%0d_match", i), {31'b0, m_def}, tv[i].m);
            chk($sformatf("vec%0d_prog", i), {30'b0, p_def}, tv[i].p);
            chk($sformatf("vec%0d_cnt", i), {24'b0, c_def}, tv[i].cnt);
        end

        // Non-overlapping mode, both streams
        drive(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, s1[i], 0);
            chk($sformatf("nov_s1_match%0d", i), {31'b0, m_nov}, {31'b0, e1[i]});
        end
        chk("nov_s1_cnt", {24'b0, c_nov}, 32'd1);
        drive(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, s2[i], 0);
            chk($sformatf("nov_s2_match%0d", i), {31'b0, m_nov}, {31'b0, e2[i]});
        end
        chk("nov_s2_cnt", {24'b0, c_nov}, 32'd2);

        // Four-bit pattern with fallback into the middle of the prefix
        drive(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, s3[i], 0);
            chk($sformatf("p4_prog%0d", i), {30'b0, p_p4}, p3[i]);
            chk($sformatf("p4_match%0d", i), {31'b0, m_p4}, {31'b0, e3[i]});
        end

        // Two-bit counter saturation, then clear coincident with a match
        drive(1, 0, 0, 0);
        for (int i = 0; i < 11; i++) begin
            drive(0, 1, 1'(i % 2), 0);
            chk($sformatf("c2_cnt%0d", i), {30'b0, c_c2}, c4[i]);
        end
        drive(0, 1, 1, 0);
        drive(0, 1, 0, 1);
        chk("c2_clr_match", {31'b0, m_c2}, 32'd1);
        chk("c2_clr_cnt", {30'b0, c_c2}, 32'd1);

        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pattern_fsm_param.md
PATTERN_FSM_PARAM -- requirements
Module: pattern_fsm_param

Interface
- REQ-001: Parameter PAT_LEN, default 3, SHALL set the pattern length in bits; legal range 2..16, and any other value SHALL fail elaboration.
- REQ-002: Parameter PATTERN, default 3'b010, width PAT_LEN, SHALL be the target sequence; PATTERN[PAT_LEN-1] is the first bit received.
- REQ-003: Parameter OVERLAP, default 1, SHALL select the mode: 1 means overlapping matches allowed, 0 means non-overlapping.
- REQ-004: Parameter CNT_W, default 8, SHALL set the match counter width; legal range 1..32.
- REQ-005: clk, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge.
- REQ-006: rst, input, 1 bit, SHALL be a synchronous, active-high reset.
- REQ-007: en, input, 1 bit, SHALL be the sample qualifier; data_in is consumed only when en=1.
- REQ-008: data_in, input, 1 bit, SHALL be the serial data bit.
- REQ-009: clr_cnt, input, 1 bit, SHALL be a synchronous clear of match_cnt.
- REQ-010: match, output, 1 bit, SHALL be a registered one-cycle pulse marking a completed pattern.
- REQ-011: match_cnt, output, CNT_W bits, SHALL be the registered, saturating count of matches.
- REQ-012: prog, output, clog2(PAT_LEN) bits, SHALL be the registered current state, i.e. the number of pattern bits currently matched (0..PAT_LEN-1).

Function
- REQ-013: The FSM SHALL have exactly PAT_LEN states, S0..S(PAT_LEN-1), where Sk means the last k consumed bits equal the first k pattern bits; prog SHALL equal k.
- REQ-014: In Sk with en=1 and data_in equal to pattern bit k (counted from the first bit), for k<PAT_LEN-1, the next state SHALL be S(k+1).
- REQ-015: In Sk with en=1 and a mismatching bit, the next state SHALL be the longest proper prefix of PATTERN that is a suffix of (matched k bits followed by data_in).
- REQ-016: The fallback table SHALL be computed at elaboration; no runtime comparator chain over history.
- REQ-017: In S(PAT_LEN-1) with en=1 and the correct final bit, match SHALL be 1 in the following cycle (latency 1 clk after the final bit's sampling edge).
- REQ-018: After a full match with OVERLAP=1, the next state SHALL be the longest proper prefix of PATTERN that is also a suffix of PATTERN.
- REQ-019: After a full match with OVERLAP=0, the next state SHALL be S0.
- REQ-020: When en=0, state SHALL hold and match SHALL be 0 in the next cycle.
- REQ-021: match SHALL be 0 in every cycle not covered by REQ-017.
- REQ-022: On a match event, match_cnt SHALL increment by 1, saturating at 2^CNT_W-1 (no wrap).
- REQ-023: clr_cnt=1 without a match event SHALL set match_cnt to 0 next cycle.
- REQ-024: clr_cnt=1 coincident with a match event SHALL set match_cnt to 1.
- REQ-025: clr_cnt SHALL NOT affect state or match.
- REQ-026: Any unreachable state encoding SHALL recover to S0 with match=0 on the next edge.

Reset
- REQ-027: rst=1 at a clock edge SHALL force state=S0, prog=0, match=0 and match_cnt=0, overriding en, data_in and clr_cnt.
- REQ-028: rst asserted mid-pattern SHALL discard partial progress; bits consumed before reset SHALL NOT contribute to any later match.

Verification
- REQ-029: Defaults, en=1, stream 0,1,0,1,0 -> match pulses the cycle after bit 3 and after bit 5; match_cnt=2.
- REQ-030: OVERLAP=0, same stream 0,1,0,1,0 -> single match after bit 3; match_cnt=1; stream 0,1,0,0,1,0 -> two matches.
- REQ-031: PAT_LEN=4, PATTERN=4'b1011, stream 1,0,1,0,1,1 -> prog sequence 1,2,3,2,3, then match after bit 6; no earlier match.
- REQ-032: Defaults, stream 0,1 then en=0 for 3 cycles then en=1 with 0 -> prog holds 2 during the gap; match after the final 0; match=0 throughout the gap.
- REQ-033: CNT_W=2, 5 matches -> match_cnt reads 1,2,3,3,3; clr_cnt coincident with the 6th match -> match_cnt=1.
- REQ-034: Defaults, stream 0,1, rst=1 for one cycle, then 0 -> no match; prog=1 after the 0; match_cnt=0.
